mem_controller: RTL and testbench

Upstream neighbour of the instruction cache: owns the single byte-wide RAM/IO port and serves two clients, instruction-line refills (8 bytes) and load/store-buffer accesses (1/2/4 bytes). Requests are serialised byte by byte, reads are reassembled little-endian, and each access completes with a one-cycle done pulse. Data-port requests have priority over instruction refills. Speculative reads are aborted on misprediction clear; writes always complete.

---
 rtl/mem_controller_if.sv | 46 ++++
 rtl/mem_controller.sv | 162 ++++++++++++++++
 tb/tb_mem_controller.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_controller_if.sv
// rtl/mem_controller_if.sv - byte-wide RAM/IO port plus i-cache and load/store-buffer client signals
interface mem_controller_if #(
   parameter int LINE_WIDTH = 64
);
   // RAM/IO port
   logic [7:0]            mem_din;
   logic [7:0]            mem_dout;
   logic [31:0]           mem_a;
   logic                  mem_wr;
   logic                  io_buffer_full;

   // instruction-line refill client
   logic                  icache_signal;
   logic [31:0]           icache_addr;
   logic                  icache_done;
   logic [LINE_WIDTH-1:0] icache_data;

   // load/store-buffer client
   logic                  lsb_signal;
   logic                  lsb_wr;
   logic [1:0]            lsb_len;
   logic [31:0]           lsb_addr;
   logic [31:0]           lsb_wdata;
   logic                  lsb_done;
   logic [31:0]           lsb_rdata;

   // environment side: clients and RAM
   modport master (
      output mem_din, io_buffer_full,
      output icache_signal, icache_addr,
      output lsb_signal, lsb_wr, lsb_len, lsb_addr, lsb_wdata,
      input  mem_dout, mem_a, mem_wr,
      input  icache_done, icache_data,
      input  lsb_done, lsb_rdata
   );

   // controller side
   modport slave (
      input  mem_din, io_buffer_full,
      input  icache_signal, icache_addr,
      input  lsb_signal, lsb_wr, lsb_len, lsb_addr, lsb_wdata,
      output mem_dout, mem_a, mem_wr,
      output icache_done, icache_data,
      output lsb_done, lsb_rdata
   );
endinterface

// File: rtl/mem_controller.sv
// rtl/mem_controller.sv - serialises i-cache refills and LSB accesses onto a byte-wide RAM/IO port
module mem_controller #(
   parameter int          LINE_WIDTH = 64,
   parameter logic [31:0] IO_BASE    = 32'h00030000
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       rdy_in,
   input  logic       clear_signal,
   mem_controller_if.slave bus
);

   localparam int LINE_BYTES = LINE_WIDTH / 8;
   localparam int CW         = $clog2(LINE_BYTES + 1);
   localparam int IW         = $clog2(LINE_BYTES);

   typedef enum logic [2:0] {
      IDLE,
      IFETCH,
      DREAD,
      DWRITE,
      DONE
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         len;
   logic [CW-1:0]         lsb_len_bytes;
   logic [LINE_WIDTH-1:0] rbuf;
   logic [LINE_WIDTH-1:0] rbuf_next;
   logic [23:0]           wbuf;
   logic [IW-1:0]         rd_idx;
   logic                  io_stall;
   logic                  reading;
   logic                  accept_lsb;
   logic                  accept_ic;
   logic                  finish;

   // A write into the IO region waits while the IO buffer is full.
   assign io_stall    = bus.io_buffer_full && (bus.mem_a[31:16] == IO_BASE[31:16]);
   assign bus.mem_wr  = rdy_in && (state == DWRITE) && !io_stall;
   assign reading     = (state == IFETCH) || (state == DREAD);
   // cnt runs one ahead of the byte arriving on mem_din (RAM has one cycle latency)
   assign rd_idx      = cnt[IW-1:0] - IW'(1);

   // Decode the LSB length; the illegal code 11 is served as a word.
   always_comb begin
      lsb_len_bytes = CW'(4);
      case (bus.lsb_len)
         2'b00:   lsb_len_bytes = CW'(1);
         2'b01:   lsb_len_bytes = CW'(2);
         default: lsb_len_bytes = CW'(4);
      endcase
   end

   // Merge the byte currently on mem_din into the read buffer.
   always_comb begin
      rbuf_next = rbuf;
      if (cnt != '0) begin
         rbuf_next[{rd_idx, 3'b000} +: 8] = bus.mem_din;
      end
   end

   // Next-state and control strobes; LSB has priority, nothing is accepted on a flush.
   always_comb begin
      state_next = state;
      accept_lsb = 1'b0;
      accept_ic  = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (!clear_signal) begin
               if (bus.lsb_signal) begin
                  accept_lsb = 1'b1;
                  state_next = bus.lsb_wr ? DWRITE : DREAD;
               end else if (bus.icache_signal) begin
                  accept_ic  = 1'b1;
                  state_next = IFETCH;
               end
            end
         end
         IFETCH, DREAD: begin
            if (clear_signal) begin
               state_next = IDLE;
            end else if (cnt == len) begin
               finish     = 1'b1;
               state_next = DONE;
            end
         end
         DWRITE: begin
            if (!io_stall && (cnt == len - CW'(1))) begin
               finish     = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register, frozen while rdy_in is low.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state <= IDLE;
      end else if (rdy_in) begin
         state <= state_next;
      end
   end

   // Address walk, byte counter, read reassembly, write serialisation and done pulses.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         cnt             <= '0;
         len             <= '0;
         rbuf            <= '0;
         wbuf            <= '0;
         bus.mem_a       <= '0;
         bus.mem_dout    <= '0;
         bus.icache_done <= 1'b0;
         bus.lsb_done    <= 1'b0;
         bus.icache_data <= '0;
         bus.lsb_rdata   <= '0;
      end else if (rdy_in) begin
         bus.icache_done <= finish && (state == IFETCH);
         bus.lsb_done    <= finish && (state != IFETCH);
         if (accept_lsb || accept_ic) begin
            cnt       <= '0;
            rbuf      <= '0;
            bus.mem_a <= accept_lsb ? bus.lsb_addr : bus.icache_addr;
            len       <= accept_lsb ? lsb_len_bytes : CW'(LINE_BYTES);
            if (accept_lsb && bus.lsb_wr) begin
               bus.mem_dout <= bus.lsb_wdata[7:0];
               wbuf         <= bus.lsb_wdata[31:8];
            end
         end else if (reading && !clear_signal) begin
            rbuf <= rbuf_next;
            cnt  <= cnt + CW'(1);
            if (cnt < len - CW'(1)) begin
               bus.mem_a <= bus.mem_a + 32'd1;
            end
            if (finish) begin
               if (state == IFETCH) begin
                  bus.icache_data <= rbuf_next;
               end else begin
                  bus.lsb_rdata <= rbuf_next[31:0];
               end
            end
         end else if ((state == DWRITE) && !io_stall && !finish) begin
            cnt          <= cnt + CW'(1);
            bus.mem_a    <= bus.mem_a + 32'd1;
            bus.mem_dout <= wbuf[7:0];
            wbuf         <= {8'h00, wbuf[23:8]};
         end
      end
   end

endmodule

// File: tb/tb_mem_controller.sv
// tb/tb_mem_controller.sv - directed self-checking bench for mem_controller
module tb_mem_controller;

   logic clk_in = 1'b0;
   logic rst_in;
   logic rdy_in;
   logic clear_signal;

   mem_controller_if #(.LINE_WIDTH(64)) bus ();

   mem_controller #(
      .LINE_WIDTH (64),
      .IO_BASE    (32'h00030000)
   ) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .rdy_in       (rdy_in),
      .clear_signal (clear_signal),
      .bus          (bus)
   );

   always #5 clk_in = ~clk_in;

   logic [7:0]  ram [0:65535];
   logic [31:0] wq_a [$];
   logic [7:0]  wq_d [$];

   // RAM model: one-cycle read latency, write log of every issued byte
   always @(posedge clk_in) begin
      bus.mem_din <= ram[bus.mem_a[15:0]];
      if (bus.mem_wr) begin
         ram[bus.mem_a[15:0]] <= bus.mem_dout;
         wq_a.push_back(bus.mem_a);
         wq_d.push_back(bus.mem_dout);
      end
   end

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] a_log  [0:23];
   logic        wr_log [0:23];
   int          ic_k, lsb_k, ic_n, lsb_n;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_writes(input string tag, input logic [31:0] base,
                               input logic [31:0] data, input int n);
      logic [31:0] d;
      d = data;
      check({tag, "_count"}, 64'(wq_a.size()), 64'(n));
      for (int i = 0; i < n; i++) begin
         if (i < wq_a.size()) begin
            check({tag, "_addr"}, 64'(wq_a[i]), 64'(base + 32'(i)));
            check({tag, "_data"}, 64'(wq_d[i]), 64'(d[7:0]));
         end
         d = d >> 8;
      end
   endtask

   // Runs one scenario for 24 cycles starting at a negedge in acceptance cycle T (k=0).
   task automatic run(input bit ic_req, input logic [31:0] ic_a,
                      input bit lsb_req, input bit wr, input logic [1:0] len,
                      input logic [31:0] la, input logic [31:0] wd,
                      input int clr_k, input bit clr_drop,
                      input int io_lo, input int io_hi,
                      input int rdy_lo, input int rdy_hi, input int rst_k);
      ic_k = -1; lsb_k = -1; ic_n = 0; lsb_n = 0;
      wq_a.delete();
      wq_d.delete();
      bus.icache_signal = ic_req;
      bus.icache_addr   = ic_a;
      bus.lsb_signal    = lsb_req;
      bus.lsb_wr        = wr;
      bus.lsb_len       = len;
      bus.lsb_addr      = la;
      bus.lsb_wdata     = wd;
      for (int k = 0; k < 24; k++) begin
         clear_signal       = (k == clr_k);
         bus.io_buffer_full = (k >= io_lo) && (k <= io_hi);
         rdy_in             = !((k >= rdy_lo) && (k <= rdy_hi));
         rst_in             = (k != rst_k);
         if ((k == clr_k && clr_drop) || k == rst_k) bus.icache_signal = 1'b0;
         #1;
         a_log[k]  = bus.mem_a;
         wr_log[k] = bus.mem_wr;
         if (bus.icache_done) begin
            ic_n++;
            if (ic_k < 0) ic_k = k;
            bus.icache_signal = 1'b0;
         end
         if (bus.lsb_done) begin
            lsb_n++;
            if (lsb_k < 0) lsb_k = k;
            bus.lsb_signal = 1'b0;
         end
         @(posedge clk_in);
         @(negedge clk_in);
      end
      clear_signal       = 1'b0;
      bus.io_buffer_full = 1'b0;
      rdy_in             = 1'b1;
      rst_in             = 1'b1;
      bus.icache_signal  = 1'b0;
      bus.lsb_signal     = 1'b0;
   endtask

   initial begin
      int nwr;
      rst_in = 1'b0; rdy_in = 1'b1; clear_signal = 1'b0;
      bus.io_buffer_full = 1'b0;
      bus.icache_signal = 1'b0; bus.icache_addr = '0;
      bus.lsb_signal = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_len = '0;
      bus.lsb_addr = '0; bus.lsb_wdata = '0;
      for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
      for (int i = 0; i < 8; i++) begin
         ram[16'h0100 + i] = 8'(i + 1);
         ram[16'h0108 + i] = 8'(8'h10 + i);
      end
      ram[16'h0200] = 8'hAA; ram[16'h0201] = 8'hBB;
      ram[16'h0202] = 8'hCC; ram[16'h0203] = 8'hDD;

      repeat (3) @(negedge clk_in);
      check("rst_mem_a", 64'(bus.mem_a), 64'h0);
      check("rst_mem_dout", 64'(bus.mem_dout), 64'h0);
      check("rst_mem_wr", 64'(bus.mem_wr), 64'h0);
      check("rst_dones", 64'({bus.icache_done, bus.lsb_done}), 64'h0);
      check("rst_icache_data", bus.icache_data, 64'h0);
      check("rst_lsb_rdata", 64'(bus.lsb_rdata), 64'h0);
      rst_in = 1'b1;
      @(negedge clk_in);

      // line refill at 0x100
      run(1, 32'h100, 0, 0, 2'b00, 0, 0, -1, 0, -1, -1, -1, -1, -1);
      check("if_done_k", 64'(ic_k), 64'd10);
      check("if_done_n", 64'(ic_n), 64'd1);
      check("if_data", bus.icache_data, 64'h0807060504030201);
      for (int i = 1; i <= 8; i++) check("if_mem_a", 64'(a_log[i]), 64'(32'h100 + 32'(i - 1)));
      check("if_no_wr", 64'(wq_a.size()), 64'd0);

      // 4-byte load
      run(0, 0, 1, 0, 2'b10, 32'h200, 0, -1, 0, -1, -1, -1, -1, -1);
      check("ld4_done_k", 64'(lsb_k), 64'd6);
      check("ld4_rdata", 64'(bus.lsb_rdata), 64'hDDCCBBAA);

      // 1-byte load, upper bytes must clear
      run(0, 0, 1, 0, 2'b00, 32'h200, 0, -1, 0, -1, -1, -1, -1, -1);
      check("ld1_done_k", 64'(lsb_k), 64'd3);
      check("ld1_rdata", 64'(bus.lsb_rdata), 64'h000000AA);

      // 2-byte load wrapping past 0xFFFFFFFF
      ram[16'hFFFF] = 8'h5A; ram[16'h0000] = 8'hC3;
      run(0, 0, 1, 0, 2'b01, 32'hFFFFFFFF, 0, -1, 0, -1, -1, -1, -1, -1);
      check("wrap_a0", 64'(a_log[1]), 64'hFFFFFFFF);
      check("wrap_a1", 64'(a_log[2]), 64'h0);
      check("wrap_done_k", 64'(lsb_k), 64'd4);
      check("wrap_rdata", 64'(bus.lsb_rdata), 64'h0000C35A);

      // 2-byte IO store stalled on io_buffer_full in T+1..T+3
      run(0, 0, 1, 1, 2'b01, 32'h30000, 32'h1234, -1, 0, 1, 3, -1, -1, -1);
      check("io_stall_wr", 64'({wr_log[1], wr_log[2], wr_log[3]}), 64'h0);
      check("io_wr_k4", 64'(wr_log[4]), 64'h1);
      check_writes("io_st", 32'h30000, 32'h1234, 2);
      check("io_done_k", 64'(lsb_k), 64'd6);
      check("io_done_n", 64'(lsb_n), 64'd1);

      // simultaneous requests: LSB first, refill right after DONE
      run(1, 32'h100, 1, 0, 2'b00, 32'h200, 0, -1, 0, -1, -1, -1, -1, -1);
      check("pri_lsb_k", 64'(lsb_k), 64'd3);
      check("pri_lsb_rdata", 64'(bus.lsb_rdata), 64'h000000AA);
      check("pri_ic_k", 64'(ic_k), 64'd14);
      check("pri_ic_data", bus.icache_data, 64'h0807060504030201);

      // clear in IDLE delays acceptance by one cycle
      run(1, 32'h100, 0, 0, 2'b00, 0, 0, 0, 0, -1, -1, -1, -1, -1);
      check("clr_idle_k", 64'(ic_k), 64'd11);

      // clear during refill byte 4: abort, no done, data untouched
      run(1, 32'h108, 0, 0, 2'b00, 0, 0, 5, 1, -1, -1, -1, -1, -1);
      check("clr_if_n", 64'(ic_n), 64'd0);
      check("clr_if_a", 64'(a_log[7]), 64'h10C);
      check("clr_if_data", bus.icache_data, 64'h0807060504030201);

      // clear during a 4-byte store is ignored
      run(0, 0, 1, 1, 2'b10, 32'h400, 32'h11223344, 2, 0, -1, -1, -1, -1, -1);
      check_writes("clr_st", 32'h400, 32'h11223344, 4);
      check("clr_st_k", 64'(lsb_k), 64'd5);

      // rdy_in low for T+2..T+4 during a 4-byte store
      run(0, 0, 1, 1, 2'b10, 32'h500, 32'hA1B2C3D4, -1, 0, -1, -1, 2, 4, -1);
      nwr = int'(wr_log[2]) + int'(wr_log[3]) + int'(wr_log[4]);
      check("rdy_pause_wr", 64'(nwr), 64'd0);
      check_writes("rdy_st", 32'h500, 32'hA1B2C3D4, 4);
      check("rdy_st_k", 64'(lsb_k), 64'd8);

      // reset in the middle of a refill
      run(1, 32'h100, 0, 0, 2'b00, 0, 0, -1, 0, -1, -1, -1, -1, 5);
      check("rst_if_a", 64'(a_log[6]), 64'h0);
      check("rst_if_n", 64'(ic_n), 64'd0);
      check("rst_if_data", bus.icache_data, 64'h0);
      check("rst_if_rdata", 64'(bus.lsb_rdata), 64'h0);
      check("rst_if_dout", 64'(bus.mem_dout), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
